// File: rtl/node_addr_translator.sv
// Node-relative to physical address translator for the NoC memory controller.
// Maps node word addresses into the private or shared window and queues them for the memory port.
module node_addr_translator #(
   parameter int X_BITS      = 2,
   parameter int Y_BITS      = 2,
   parameter int LOCAL_BITS  = 10,
   parameter int SHARED_BITS = 9,
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 4,
   parameter bit STRICT      = 1'b1
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [X_BITS+Y_BITS-1:0] NODEADDRESS,
   input  logic                     REQ_VALID,
   output logic                     REQ_READY,
   input  logic [ADDR_W-1:0]        REQ_ADDR,
   input  logic                     REQ_WRITE,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [ADDR_W-1:0]        OUT_ADDR,
   output logic                     OUT_WRITE,
   output logic                     OUT_SHARED,
   output logic                     FAULT,
   output logic [ADDR_W-1:0]        FAULT_ADDR,
   input  logic                     FAULT_CLR,
   output logic [15:0]              LOCAL_CNT,
   output logic [15:0]              SHARED_CNT
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] L_LIM   = ADDR_W'(1) << LOCAL_BITS;
   localparam logic [ADDR_W-1:0] S_LIM   = ADDR_W'(1) << SHARED_BITS;
   localparam logic [ADDR_W-1:0] WIN_LIM = L_LIM + S_LIM;
   localparam logic [ADDR_W-1:0] SH_BASE = ADDR_W'(1) << (LOCAL_BITS + X_BITS + Y_BITS);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              wr;
      logic              sh;
   } ent_t;

   ent_t            mem [DEPTH];
   ent_t            new_ent;
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [PW:0]     cnt;
   logic [X_BITS-1:0] node_x;
   logic [Y_BITS-1:0] node_y;
   logic            is_local, oow, drop, accept, push, pop;

   assign node_x = NODEADDRESS[X_BITS+Y_BITS-1:Y_BITS];
   assign node_y = NODEADDRESS[Y_BITS-1:0];

   always_comb begin
      is_local    = REQ_ADDR < L_LIM;
      oow         = REQ_ADDR >= WIN_LIM;
      new_ent.wr  = REQ_WRITE;
      new_ent.sh  = !is_local;
      if (is_local)
         new_ent.addr = (ADDR_W'(node_x) << (LOCAL_BITS + Y_BITS))
                      + (ADDR_W'(node_y) << LOCAL_BITS) + REQ_ADDR;
      else
         new_ent.addr = SH_BASE + ADDR_W'(REQ_ADDR[SHARED_BITS-1:0]);
   end

   // Out-of-window requests still complete the handshake; in strict mode they never reach the FIFO.
   assign drop      = STRICT && oow;
   assign REQ_READY = cnt < (PW+1)'(DEPTH);
   assign OUT_VALID = cnt != '0;
   assign accept    = REQ_VALID && REQ_READY;
   assign push      = accept && !drop;
   assign pop       = OUT_VALID && OUT_READY;

   assign OUT_ADDR   = mem[rd_ptr].addr;
   assign OUT_WRITE  = mem[rd_ptr].wr;
   assign OUT_SHARED = mem[rd_ptr].sh;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         cnt        <= '0;
         FAULT      <= 1'b0;
         FAULT_ADDR <= '0;
         LOCAL_CNT  <= '0;
         SHARED_CNT <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= new_ent;
            wr_ptr      <= wr_ptr + PW'(1);
            if (!new_ent.sh && LOCAL_CNT != 16'hFFFF)  LOCAL_CNT  <= LOCAL_CNT + 16'd1;
            if (new_ent.sh && SHARED_CNT != 16'hFFFF)  SHARED_CNT <= SHARED_CNT + 16'd1;
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (PW+1)'(1);
            2'b01:   cnt <= cnt - (PW+1)'(1);
            default: cnt <= cnt;
         endcase
         // A new fault beats a simultaneous clear, and always records its own address then.
         if (accept && drop) begin
            FAULT <= 1'b1;
            if (!FAULT || FAULT_CLR) FAULT_ADDR <= REQ_ADDR;
         end else if (FAULT_CLR) begin
            FAULT      <= 1'b0;
            FAULT_ADDR <= '0;
         end
      end
   end

endmodule

// File: tb/tb_node_addr_translator.sv
// Scoreboard bench: issued requests push expected outputs; monitors pop and compare on each output transfer.
module tb_node_addr_translator;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  node = 4'b1001;
   logic        req_valid, req_valid0, req_write, out_ready, fault_clr;
   logic [31:0] req_addr;
   logic        req_ready, out_valid, out_write, out_shared, fault;
   logic [31:0] out_addr, fault_addr;
   logic [15:0] local_cnt, shared_cnt;
   logic        req_ready0, out_valid0, out_write0, out_shared0, fault0;
   logic [31:0] out_addr0, fault_addr0;
   logic [15:0] local_cnt0, shared_cnt0;

   int vecs = 0;
   int errs = 0;
   int exp_local = 0;
   int exp_shared = 0;
   logic [33:0] q [$];
   logic [33:0] q0 [$];

   always #5 clk = ~clk;

   node_addr_translator #(.STRICT(1'b1)) dut (
      .CLK(clk), .RESET(rst), .NODEADDRESS(node),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_ADDR(req_addr), .REQ_WRITE(req_write),
      .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_ADDR(out_addr), .OUT_WRITE(out_write),
      .OUT_SHARED(out_shared), .FAULT(fault), .FAULT_ADDR(fault_addr), .FAULT_CLR(fault_clr),
      .LOCAL_CNT(local_cnt), .SHARED_CNT(shared_cnt));

   node_addr_translator #(.STRICT(1'b0)) dut0 (
      .CLK(clk), .RESET(rst), .NODEADDRESS(node),
      .REQ_VALID(req_valid0), .REQ_READY(req_ready0), .REQ_ADDR(req_addr), .REQ_WRITE(req_write),
      .OUT_VALID(out_valid0), .OUT_READY(1'b1), .OUT_ADDR(out_addr0), .OUT_WRITE(out_write0),
      .OUT_SHARED(out_shared0), .FAULT(fault0), .FAULT_ADDR(fault_addr0), .FAULT_CLR(1'b0),
      .LOCAL_CNT(local_cnt0), .SHARED_CNT(shared_cnt0));

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Output transfers happen at the next rising edge; inputs are stable at the falling edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) chk("unexpected_out", {out_addr, out_write, out_shared}, 34'h3_ffff_ffff);
         else chk("out_entry", {out_addr, out_write, out_shared}, q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid0) begin
         if (q0.size() == 0) chk("unexpected_out0", {out_addr0, out_write0, out_shared0}, 34'h3_ffff_ffff);
         else chk("out_entry0", {out_addr0, out_write0, out_shared0}, q0.pop_front());
      end
   end

   task automatic send(input logic [31:0] a, input logic w, input logic [31:0] ea,
                       input logic esh, input logic epush);
      int n = 0;
      req_valid = 1'b1; req_addr = a; req_write = w;
      @(negedge clk);
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) chk("req_ready_timeout", {33'd0, req_ready}, 34'd1);
      else if (epush) begin
         q.push_back({ea, w, esh});
         if (esh) exp_shared++; else exp_local++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
      #1;
      chk("drain", 34'(q.size()), 34'd0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 0; req_valid0 = 0; req_write = 0; req_addr = 0;
      out_ready = 0; fault_clr = 0;
      idle(2);
      chk("rst_req_ready", {33'd0, req_ready}, 34'd1);
      chk("rst_out_valid", {33'd0, out_valid}, 34'd0);
      chk("rst_out", {out_addr, out_write, out_shared}, 34'd0);
      chk("rst_fault", {fault_addr, 1'b0, fault}, 34'd0);
      chk("rst_cnts", {2'b0, local_cnt, shared_cnt}, 34'd0);
      rst = 1'b0;
      out_ready = 1'b1;

      send(32'd5, 1'b0, 32'd9221, 1'b0, 1'b1);
      chk("latency_valid", {33'd0, out_valid}, 34'd1);
      chk("local_cnt_1", {18'd0, local_cnt}, 34'd1);
      send(32'd1030, 1'b1, 32'd16390, 1'b1, 1'b1);
      idle(2);
      chk("shared_cnt_1", {18'd0, shared_cnt}, 34'd1);

      // strict faults: no FIFO entry, first address held
      send(32'd1536, 1'b0, 32'd0, 1'b0, 1'b0);
      send(32'd2000, 1'b0, 32'd0, 1'b0, 1'b0);
      chk("fault_no_valid", {33'd0, out_valid}, 34'd0);
      chk("fault_set", {33'd0, fault}, 34'd1);
      chk("fault_addr_first", {2'b0, fault_addr}, 34'd1536);
      chk("fault_cnts", {2'b0, local_cnt, shared_cnt}, {2'b0, 16'd1, 16'd1});
      fault_clr = 1'b1; idle(1); fault_clr = 1'b0;
      chk("fault_clr", {fault_addr, 1'b0, fault}, 34'd0);
      send(32'd1700, 1'b0, 32'd0, 1'b0, 1'b0);
      fault_clr = 1'b1;
      send(32'd1800, 1'b0, 32'd0, 1'b0, 1'b0);
      fault_clr = 1'b0;
      chk("fault_beats_clr", {fault_addr, 1'b0, fault}, {32'd1800, 1'b0, 1'b1});
      fault_clr = 1'b1; idle(1); fault_clr = 1'b0;

      // non-strict instance aliases into the shared window
      q0.push_back({32'd16384, 1'b1, 1'b1});
      req_addr = 32'd1536; req_write = 1'b1; req_valid0 = 1'b1;
      idle(1);
      req_valid0 = 1'b0;
      idle(2);
      chk("alias_no_fault", {33'd0, fault0}, 34'd0);
      chk("alias_drained", 34'(q0.size()), 34'd0);

      // fill with the memory port stalled, then drain with wrap-around over several refills
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(32'd10 + i, i[0], 32'd9226 + i, 1'b0, 1'b1);
      chk("full_ready_low", {33'd0, req_ready}, 34'd0);
      req_valid = 1'b1; req_addr = 32'd14;
      idle(2);
      chk("full_still_low", {33'd0, req_ready}, 34'd0);
      out_ready = 1'b1;
      send(32'd14, 1'b0, 32'd9230, 1'b0, 1'b1);
      drain();
      for (int r = 0; r < 3; r++) begin
         out_ready = 1'b0;
         send(32'd100 + r, 1'b1, 32'd9316 + r, 1'b0, 1'b1);
         send(32'd1100 + r, 1'b0, 32'd16460 + r, 1'b1, 1'b1);
         send(32'd1535, 1'b1, 32'd16895, 1'b1, 1'b1);
         send(32'd1023, 1'b0, 32'd10239, 1'b0, 1'b1);
         chk("refill_full", {33'd0, req_ready}, 34'd0);
         out_ready = 1'b1;
         drain();
      end
      // streaming back-to-back with the port always ready
      for (int i = 0; i < 6; i++) send(32'd1024 + i, 1'b0, 32'd16384 + i, 1'b1, 1'b1);
      drain();
      chk("cnt_local", {2'b0, local_cnt, shared_cnt}, {2'b0, 16'(exp_local), 16'(exp_shared)});

      // asynchronous reset mid-operation
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(32'd20 + i, 1'b0, 32'd9236 + i, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      q.delete();
      exp_local = 0; exp_shared = 0;
      chk("arst_valid", {33'd0, out_valid}, 34'd0);
      chk("arst_ready", {33'd0, req_ready}, 34'd1);
      chk("arst_cnts", {2'b0, local_cnt, shared_cnt}, 34'd0);
      idle(1);
      rst = 1'b0;
      out_ready = 1'b1;
      send(32'd7, 1'b1, 32'd9223, 1'b0, 1'b1);
      drain();
      chk("post_rst_cnt", {18'd0, local_cnt}, 34'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
